clk_div_ctrl: RTL and testbench

- Run-time programmable clock-enable controller for the LDPC decoder fabric.
- Generates a divided square wave (div_clk) and a one-cycle tick on each half-period boundary.
- Accepts new divide factors over a valid/ready handshake and applies them only at a full-period boundary, so the output never glitches.
- Supports clean start/stop of the divided clock, ending on a completed period.

---
 rtl/clk_div_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable controller: glitch-free divided square wave plus half-period tick.
// Optional period counter output is enabled by defining CLK_DIV_CTRL_CNT_EN.
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 200
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             tick,
    output logic             busy
`ifdef CLK_DIV_CTRL_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t           state_reg,      state_next;
    logic [WIDTH-1:0] count_reg,      count_next;
    logic [WIDTH-1:0] active_div_reg, active_div_next;
    logic [WIDTH-1:0] pend_div_reg,   pend_div_next;
    logic             pend_reg,       pend_next;
    logic             div_clk_reg,    div_clk_next;
    logic             tick_reg,       tick_next;
    logic             cfg_err_reg,    cfg_err_next;

    logic [WIDTH-1:0] half_m1;
    logic             at_boundary;
    logic             stopping;
    logic             cfg_take;
    logic             div_ok;

    assign half_m1     = (active_div_reg >> 1) - WIDTH'(1);
    assign at_boundary = (count_reg == half_m1);
    assign stopping    = (state_reg == ST_STOP) && !run;
    assign cfg_take    = cfg_valid && !pend_reg;
    // Even and non-zero implies >= 2.
    assign div_ok      = !cfg_div[0] && (cfg_div != '0);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            active_div_reg <= WIDTH'(DEFAULT_DIV);
            pend_div_reg   <= '0;
            pend_reg       <= 1'b0;
            div_clk_reg    <= 1'b0;
            tick_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            active_div_reg <= active_div_next;
            pend_div_reg   <= pend_div_next;
            pend_reg       <= pend_next;
            div_clk_reg    <= div_clk_next;
            tick_reg       <= tick_next;
            cfg_err_reg    <= cfg_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        active_div_next = active_div_reg;
        pend_div_next   = pend_div_reg;
        pend_next       = pend_reg;
        div_clk_next    = div_clk_reg;
        tick_next       = 1'b0;
        cfg_err_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                count_next   = '0;
                div_clk_next = 1'b0;
                if (pend_reg) begin
                    active_div_next = pend_div_reg;
                    pend_next       = 1'b0;
                end
                if (run) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN, ST_STOP: begin
                state_next = run ? ST_RUN : ST_STOP;
                if (at_boundary) begin
                    count_next = '0;
                    if (stopping && !div_clk_reg) begin
                        // Low half already finished: suppress the rising edge and park.
                        state_next = ST_IDLE;
                    end else begin
                        div_clk_next = !div_clk_reg;
                        tick_next    = 1'b1;
                        if (div_clk_reg) begin
                            // Falling edge closes a full period: safe point for a new factor.
                            if (pend_reg) begin
                                active_div_next = pend_div_reg;
                                pend_next       = 1'b0;
                            end
                            if (stopping) begin
                                state_next = ST_IDLE;
                            end
                        end
                    end
                end else begin
                    count_next = count_reg + WIDTH'(1);
                end
            end
            default: begin
                state_next   = ST_IDLE;
                count_next   = '0;
                div_clk_next = 1'b0;
            end
        endcase

        // pend_reg is low whenever a transfer happens, so this never collides with an apply.
        if (cfg_take) begin
            if (div_ok) begin
                pend_next     = 1'b1;
                pend_div_next = cfg_div;
            end else begin
                cfg_err_next = 1'b1;
            end
        end
    end

    assign cfg_ready = !pend_reg;
    assign cfg_err   = cfg_err_reg;
    assign div_clk   = div_clk_reg;
    assign tick      = tick_reg;
    assign busy      = (state_reg != ST_IDLE);

`ifdef CLK_DIV_CTRL_CNT_EN
    logic [15:0] period_cnt_reg;
    logic        full_period;
    logic        enter_run;

    assign full_period = (state_reg != ST_IDLE) && at_boundary && div_clk_reg;
    assign enter_run   = (state_reg == ST_IDLE) && run;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            period_cnt_reg <= '0;
        end else if (enter_run) begin
            period_cnt_reg <= '0;
        end else if (full_period && (period_cnt_reg != 16'hFFFF)) begin
            period_cnt_reg <= period_cnt_reg + 16'd1;
        end
    end

    assign period_cnt = period_cnt_reg;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: per-cycle comparison against a phase-level model
// plus literal tick-spacing and handshake expectations.
module tb_clk_div_ctrl;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 200;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic             run    = 1'b0;
    logic [WIDTH-1:0] cfg_div = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_clk;
    logic             tick;
    logic             busy;

    int checks = 0;
    int errors = 0;

    clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .run       (run),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    // Model: mode 0 idle, 1 running, 2 stopping; tracks level and time spent in the current half.
    int m_mode;
    int m_level;
    int m_elapsed;
    int m_div;
    int m_tick;
    int m_err;
    int m_pend[$];

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_level = 0; m_elapsed = 0; m_div = DEFAULT_DIV;
            m_tick = 0; m_err = 0; m_pend.delete();
        end else begin : model_step
            int  half;
            bit  accept;
            accept = cfg_valid && (m_pend.size() == 0);
            m_err  = (accept && ((cfg_div < 2) || (cfg_div % 2 != 0))) ? 1 : 0;
            m_tick = 0;
            if (m_mode == 0) begin
                if (m_pend.size() != 0) m_div = m_pend.pop_front();
                m_level = 0;
                if (run) begin
                    m_mode = 1;
                    m_elapsed = 0;
                end
            end else begin
                half = m_div / 2;
                m_elapsed++;
                if (m_elapsed == half) begin
                    m_elapsed = 0;
                    if (m_mode == 2 && !run && m_level == 0) begin
                        m_mode = 0;
                    end else begin
                        m_level = 1 - m_level;
                        m_tick  = 1;
                        if (m_level == 0) begin
                            if (m_pend.size() != 0) m_div = m_pend.pop_front();
                            if (m_mode == 2 && !run) m_mode = 0;
                        end
                    end
                end
                if (m_mode != 0) m_mode = run ? 1 : 2;
            end
            if (accept && m_err == 0) m_pend.push_back(int'(cfg_div));
        end
    end

    always @(posedge clk_in) begin
        #1;
        if (!rst) begin
            checks++;
            if (div_clk !== m_level[0] || tick !== m_tick[0] || busy !== (m_mode != 0) ||
                cfg_ready !== (m_pend.size() == 0) || cfg_err !== m_err[0]) begin
                errors++;
                $display("FAIL model_cmp t=%0t got div_clk=%b tick=%b busy=%b rdy=%b err=%b want %0d %0d %0d %0d %0d",
                         $time, div_clk, tick, busy, cfg_ready, cfg_err,
                         m_level, m_tick, (m_mode != 0), (m_pend.size() == 0), m_err);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    // Counts posedges until tick is seen; n = index of the edge carrying the tick.
    task automatic wait_tick(input int limit, output int n);
        bit found;
        found = 0;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk_in);
            #1;
            if (tick) begin
                n = i;
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout got none want tick within %0d cycles", limit);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_div_clk"}, int'(div_clk), 0);
        chk({tag, "_tick"}, int'(tick), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
        chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic offer_cfg(input logic [WIDTH-1:0] d);
        @(negedge clk_in);
        cfg_div   = d;
        cfg_valid = 1'b1;
        @(negedge clk_in);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got hang want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cnt;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk_in);
        rst = 1'b0;

        // Default factor: first tick half cycles after RUN entry, then 100/100.
        @(negedge clk_in);
        run = 1'b1;
        wait_tick(300, n);
        chk("first_tick_delay", n, 101);
        chk("first_tick_level", int'(div_clk), 1);
        wait_tick(300, n);
        chk("high_half_len", n, 100);
        chk("fall_level", int'(div_clk), 0);
        wait_tick(300, n);
        chk("low_half_len", n, 100);

        // New factor 10 offered mid-high phase; applied at the falling edge.
        repeat (30) @(negedge clk_in);
        cfg_div = 8'd10;
        cfg_valid = 1'b1;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("cfg_ready_drop", int'(cfg_ready), 0);
        wait_tick(300, n);
        chk("old_period_done", n, 70);
        chk("apply_fall_level", int'(div_clk), 0);
        chk("cfg_ready_back", int'(cfg_ready), 1);
        wait_tick(20, n);
        chk("new_half_a", n, 5);
        wait_tick(20, n);
        chk("new_half_b", n, 5);

        // Invalid factors are rejected with a one-cycle error.
        offer_cfg(8'd7);
        chk("err_odd", int'(cfg_err), 1);
        chk("err_odd_ready", int'(cfg_ready), 1);
        offer_cfg(8'd0);
        chk("err_zero", int'(cfg_err), 1);
        @(negedge clk_in);
        chk("err_one_cycle", int'(cfg_err), 0);
        wait_tick(20, n);
        wait_tick(20, n);
        chk("period_kept", n, 5);

        // Stop while high: finishes at the next falling edge, then silent.
        cnt = 0;
        for (int k = 0; k < 3 && !(tick && div_clk); k++) wait_tick(20, n);
        @(negedge clk_in);
        run = 1'b0;
        wait_tick(20, n);
        chk("stop_fall_delay", n, 5);
        chk("stop_level", int'(div_clk), 0);
        chk("stop_busy", int'(busy), 0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_in);
            #1;
            if (tick) cnt++;
        end
        chk("idle_no_ticks", cnt, 0);

        // Restart, then a brief stop request must not disturb the waveform.
        @(negedge clk_in);
        run = 1'b1;
        wait_tick(20, n);
        chk("restart_delay", n, 6);
        @(negedge clk_in);
        run = 1'b0;
        @(negedge clk_in);
        run = 1'b1;
        wait_tick(20, n);
        chk("resume_no_shift", n, 4);
        chk("resume_busy", int'(busy), 1);
        wait_tick(20, n);
        chk("resume_period", n, 5);

        // Reset with a config pending discards it.
        offer_cfg(8'd20);
        chk("pend_before_rst", int'(cfg_ready), 0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        wait_tick(300, n);
        chk("post_rst_first", n, 101);
        wait_tick(300, n);
        chk("post_rst_half", n, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
